vram_slot_arbiter: RTL and testbench

Time-slot arbiter sharing the single video RAM port between the raster fetch engine and the CPU, clocked from the 65 MHz pixel clock. Divides C into 5 MHz phases and groups them into a repeating 8-phase slot cycle. Video owns phase 0; CPU is served in phases 1 and 5, and in phase 0 when video is idle. Drives the RAM chip-select, address mux select and write strobe, and returns read data to each requester with a one-cycle ack.

---
 rtl/vram_slot_arbiter.sv | 112 +++++++++++
 tb/tb_vram_slot_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: 8-phase VRAM time-slot arbiter sharing one RAM port between video fetch and CPU.
// Define VRAM_REFRESH_EN to turn phase 3 into a refresh slot driven by a 7-bit row counter.
module vram_slot_arbiter #(
  parameter int DIV = 13,
  parameter int AW  = 14,
  parameter int DW  = 8
) (
  input  logic          C,
  input  logic          aR,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  output logic          vid_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    phase
);
  typedef enum logic [1:0] {
    IDLE,
    VID,
    CPU
`ifdef VRAM_REFRESH_EN
    , REF
`endif
  } state_t;
  state_t        state_q, state_d;
  logic [4:0]    div_q, div_d;
  logic [2:0]    phase_q, nxt_p;
  logic          bnd;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, vid_data_q, cpu_rdata_q;
  logic          wr_q, p0_vid_q, vid_ack_q, cpu_ack_q, vid_miss_q;
`ifdef VRAM_REFRESH_EN
  logic [6:0]    row_q;
`endif
  // The owner of the next phase is decided on the last clock of the current one.
  always_comb begin
    bnd = div_q == 5'(DIV - 1);
    div_d = bnd ? 5'd0 : div_q + 5'd1;
    nxt_p = phase_q + 3'd1;
    state_d = IDLE;
    if (nxt_p == 3'd0) state_d = vid_req ? VID : cpu_req ? CPU : IDLE;
    else if ((nxt_p == 3'd1 || nxt_p == 3'd5) && cpu_req && state_q != CPU) state_d = CPU;
`ifdef VRAM_REFRESH_EN
    else if (nxt_p == 3'd3) state_d = REF;
`endif
    addr_d = state_d == VID ? vid_addr : state_d == CPU ? cpu_addr : '0;
`ifdef VRAM_REFRESH_EN
    if (state_d == REF) addr_d = AW'(row_q);
`endif
  end
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      state_q     <= IDLE;
      div_q       <= '0;
      phase_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      wr_q        <= 1'b0;
      p0_vid_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_miss_q  <= 1'b0;
`ifdef VRAM_REFRESH_EN
      row_q       <= '0;
`endif
    end else begin
      div_q      <= div_d;
      vid_ack_q  <= bnd && state_q == VID;
      cpu_ack_q  <= bnd && state_q == CPU;
      vid_miss_q <= bnd && phase_q == 3'd1 && !p0_vid_q && vid_req;
      if (bnd) begin
        phase_q <= nxt_p;
        state_q <= state_d;
        addr_q  <= addr_d;
        wdata_q <= cpu_wdata;
        wr_q    <= state_d == CPU && cpu_we;
        if (nxt_p == 3'd0) p0_vid_q <= state_d == VID;
        if (state_q == VID) vid_data_q <= mem_rdata;
        if (state_q == CPU && !wr_q) cpu_rdata_q <= mem_rdata;
`ifdef VRAM_REFRESH_EN
        if (state_q == REF) row_q <= row_q + 7'd1;
`endif
      end
    end
  end
  // Write strobe is kept off the first and last clock of the phase for address setup/hold.
  assign mem_we    = state_q == CPU && wr_q && div_q != 5'd0 && !bnd;
  assign mem_cs    = state_q != IDLE;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;
  assign vid_miss  = vid_miss_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_wait  = cpu_req & ~cpu_ack_q;
  assign phase     = phase_q;
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: table vectors, directed corner sequences and a randomized phase-level model.
module tb_vram_slot_arbiter;
  localparam int DIV = 13;
  localparam int AW  = 14;
  localparam int DW  = 8;
  logic C = 1'b0, aR = 1'b0;
  logic vid_req, vid_ack, vid_miss, cpu_req, cpu_we, cpu_ack, cpu_wait, mem_cs, mem_we;
  logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
  logic [DW-1:0] vid_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [2:0] phase;
  vram_slot_arbiter #(.DIV(DIV), .AW(AW), .DW(DW)) dut (
    .C(C), .aR(aR),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .phase(phase)
  );
  always #5 C = ~C;
  int n_tests = 0, n_fail = 0, n = 0;
  typedef struct {
    logic vr, cr, cw;
    logic [AW-1:0] va, ca;
    logic [DW-1:0] wd, rd;
    logic e_cs0, e_we0;
    logic [AW-1:0] e_addr0;
    logic e_vack;
    int e_cack;
    logic [DW-1:0] e_vd, e_cd;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got 0x%0h, expected 0x%0h", name, n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge C);
    #2;
    n++;
  endtask
  task automatic goto(input int t);
    while (n < t) tick();
  endtask
  task automatic clear_in();
    vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
  endtask
  task automatic do_reset();
    @(negedge C);
    aR = 1'b1;
    #2;
    @(negedge C);
    aR = 1'b0;
    n = 0;
    #1;
  endtask
  initial begin
    int misses;
    int own, ph, np, nown;
    logic [AW-1:0] e_addr;
    logic e_wr, e_vack, e_cack, e_miss, p0v;
    logic [DW-1:0] e_wd, e_vd, e_cd;
    logic [6:0] row;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 14'h0123, 14'h0000, 8'h00, 8'hA5, 1'b1, 1'b0, 14'h0123, 1'b1, 0, 8'hA5, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 14'h0010, 14'h0040, 8'h00, 8'h3C, 1'b1, 1'b0, 14'h0010, 1'b1, 2, 8'h3C, 8'h3C};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 14'h0000, 14'h0200, 8'h00, 8'h5A, 1'b1, 1'b0, 14'h0200, 1'b0, 1, 8'h00, 8'h5A};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, 8'h00, 8'hFF, 1'b0, 1'b0, 14'h0000, 1'b0, 0, 8'h00, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 14'h0000, 14'h1FFF, 8'h77, 8'hC3, 1'b1, 1'b1, 14'h1FFF, 1'b0, 1, 8'h00, 8'h00};
    // Reset state and idle slot rotation
    clear_in();
    do_reset();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_cs", 32'(mem_cs), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_vack", 32'(vid_ack), 0);
    chk("rst_cack", 32'(cpu_ack), 0);
    chk("rst_miss", 32'(vid_miss), 0);
    chk("rst_vdata", 32'(vid_data), 0);
    chk("rst_crdata", 32'(cpu_rdata), 0);
    for (int t = 0; t < 16 * DIV; t++) begin
      goto(t);
      chk("idle_phase", 32'(phase), 32'((t / DIV) % 8));
      chk("idle_cs", 32'(mem_cs), 0);
    end
    // Phase-0 arbitration table
    for (int i = 0; i < 5; i++) begin
      clear_in();
      do_reset();
      goto(7 * DIV);
      vid_req = tbl[i].vr; vid_addr = tbl[i].va;
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].wd;
      mem_rdata = tbl[i].rd;
      goto(8 * DIV + 3);
      chk("tbl_cs0", 32'(mem_cs), 32'(tbl[i].e_cs0));
      chk("tbl_we0", 32'(mem_we), 32'(tbl[i].e_we0));
      if (tbl[i].e_cs0) chk("tbl_addr0", 32'(mem_addr), 32'(tbl[i].e_addr0));
      if (tbl[i].e_we0) chk("tbl_wdata0", 32'(mem_wdata), 32'(tbl[i].wd));
      goto(9 * DIV);
      chk("tbl_vack", 32'(vid_ack), 32'(tbl[i].e_vack));
      chk("tbl_cack_p1", 32'(cpu_ack), 32'(tbl[i].e_cack == 1));
      if (tbl[i].e_cack == 1) cpu_req = 1'b0;
      vid_req = 1'b0;
      #1;
      chk("tbl_wait_p1", 32'(cpu_wait), 32'(tbl[i].cr && tbl[i].e_cack == 2));
      goto(10 * DIV);
      chk("tbl_cack_p2", 32'(cpu_ack), 32'(tbl[i].e_cack == 2));
      cpu_req = 1'b0;
      goto(10 * DIV + 1);
      chk("tbl_cack_off", 32'(cpu_ack), 0);
      chk("tbl_vdata", 32'(vid_data), 32'(tbl[i].e_vd));
      chk("tbl_crdata", 32'(cpu_rdata), 32'(tbl[i].e_cd));
    end
    // CPU write raised in phase 1 is served in phase 5
    clear_in();
    do_reset();
    goto(DIV);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1FFF; cpu_wdata = 8'h77;
    goto(3 * DIV);
    chk("w5_wait", 32'(cpu_wait), 1);
    for (int d = 0; d < DIV; d++) begin
      goto(5 * DIV + d);
      chk("w5_cs", 32'(mem_cs), 1);
      chk("w5_we", 32'(mem_we), 32'(d >= 1 && d <= DIV - 2));
      chk("w5_addr", 32'(mem_addr), 32'h1FFF);
      chk("w5_wdata", 32'(mem_wdata), 32'h77);
      chk("w5_noack", 32'(cpu_ack), 0);
    end
    goto(6 * DIV);
    chk("w5_ack", 32'(cpu_ack), 1);
    chk("w5_wait_off", 32'(cpu_wait), 0);
    cpu_req = 1'b0;
    goto(6 * DIV + 1);
    chk("w5_ack_pulse", 32'(cpu_ack), 0);
    // Late video request: one miss pulse, then served next slot cycle
    clear_in();
    mem_rdata = 8'h5E;
    do_reset();
    goto(DIV);
    vid_req = 1'b1; vid_addr = 14'h0ABC;
    misses = 0;
    for (int t = 2 * DIV; t <= 10 * DIV + 1; t++) begin
      goto(t);
      misses += int'(vid_miss);
      if (t == 2 * DIV) chk("miss_p2", 32'(vid_miss), 1);
      if (t == 3 * DIV) chk("miss_noack", 32'(vid_ack), 0);
      if (t == 8 * DIV + 3) begin
        chk("miss_cs", 32'(mem_cs), 1);
        chk("miss_addr", 32'(mem_addr), 32'h0ABC);
      end
      if (t == 9 * DIV) begin
        chk("miss_vack", 32'(vid_ack), 1);
        chk("miss_vdata", 32'(vid_data), 32'h5E);
        vid_req = 1'b0;
      end
    end
    chk("miss_count", 32'(misses), 1);
    // Reset in the middle of a CPU write phase
    clear_in();
    do_reset();
    goto(4 * DIV);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0155; cpu_wdata = 8'h99;
    goto(5 * DIV + 5);
    chk("mid_cs", 32'(mem_cs), 1);
    chk("mid_we", 32'(mem_we), 1);
    #1;
    aR = 1'b1;
    #1;
    chk("ar_cs", 32'(mem_cs), 0);
    chk("ar_we", 32'(mem_we), 0);
    chk("ar_cack", 32'(cpu_ack), 0);
    chk("ar_phase", 32'(phase), 0);
    chk("ar_addr", 32'(mem_addr), 0);
    chk("ar_wdata", 32'(mem_wdata), 0);
    @(negedge C);
    aR = 1'b0;
    n = 0;
    #1;
    for (int t = 0; t < 3 * DIV; t++) begin
      goto(t);
      chk("ar_ack_timing", 32'(cpu_ack), 32'(t == 2 * DIV));
      if (t == DIV + 5) begin
        chk("ar_regrant_cs", 32'(mem_cs), 1);
        chk("ar_regrant_addr", 32'(mem_addr), 32'h0155);
        chk("ar_regrant_we", 32'(mem_we), 1);
      end
      if (t == 2 * DIV) cpu_req = 1'b0;
    end
    // Randomized traffic against a phase-level model
    clear_in();
    do_reset();
    own = 0; ph = 0; e_addr = '0; e_wr = 1'b0; e_wd = '0; e_vd = '0; e_cd = '0;
    e_vack = 1'b0; e_cack = 1'b0; e_miss = 1'b0; p0v = 1'b0; row = '0;
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < DIV; d++) begin
        if (d == 0) begin
          if (cpu_req && e_cack) cpu_req = $urandom_range(3) == 0;
          else if (!cpu_req && $urandom_range(2) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
          end
          if (vid_req && e_vack) vid_req = $urandom_range(3) == 0;
          else if (!vid_req && $urandom_range(3) == 0) begin
            vid_req = 1'b1; vid_addr = AW'($urandom);
          end
          mem_rdata = DW'($urandom);
        end
        #1;
        chk("r_phase", 32'(phase), 32'(ph));
        chk("r_cs", 32'(mem_cs), 32'(own != 0));
        chk("r_we", 32'(mem_we), 32'(own == 2 && e_wr && d >= 1 && d <= DIV - 2));
        if (own != 0) chk("r_addr", 32'(mem_addr), 32'(e_addr));
        if (own == 2 && e_wr) chk("r_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("r_vack", 32'(vid_ack), 32'(d == 0 && e_vack));
        chk("r_cack", 32'(cpu_ack), 32'(d == 0 && e_cack));
        chk("r_miss", 32'(vid_miss), 32'(d == 0 && e_miss));
        chk("r_vdata", 32'(vid_data), 32'(e_vd));
        chk("r_crdata", 32'(cpu_rdata), 32'(e_cd));
        chk("r_wait", 32'(cpu_wait), 32'(cpu_req && !(d == 0 && e_cack)));
        if (d == DIV - 1) begin
          np = (ph + 1) % 8;
          e_vack = own == 1;
          e_cack = own == 2;
          e_miss = ph == 1 && !p0v && vid_req;
          if (own == 1) e_vd = mem_rdata;
          if (own == 2 && !e_wr) e_cd = mem_rdata;
          if (own == 3) row = row + 7'd1;
          if (np == 0) nown = vid_req ? 1 : cpu_req ? 2 : 0;
          else if ((np == 1 || np == 5) && cpu_req && own != 2) nown = 2;
`ifdef VRAM_REFRESH_EN
          else if (np == 3) nown = 3;
`endif
          else nown = 0;
          e_addr = nown == 1 ? vid_addr : nown == 2 ? cpu_addr : AW'(row);
          e_wr = nown == 2 && cpu_we;
          e_wd = cpu_wdata;
          if (np == 0) p0v = nown == 1;
          own = nown;
          ph = np;
        end
        tick();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
